// File: rtl/ram_ctrl_pkg.sv
// rtl/ram_ctrl_pkg.sv - shared types and defaults for the RAM arbiter controller
package ram_ctrl_pkg;

  localparam int ADDR_W_DEF = 7;
  localparam int DATA_W_DEF = 4;

  typedef enum logic {
    CLEAR = 1'b0,
    SERVE = 1'b1
  } state_t;

  typedef enum logic {
    REQ_A = 1'b0,
    REQ_B = 1'b1
  } req_t;

endpackage

// File: rtl/rr_arb2.sv
// rtl/rr_arb2.sv - two-way round-robin grant with its priority flop
module rr_arb2
  import ram_ctrl_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic req_a,
  input  logic req_b,
  output logic gnt_a,
  output logic gnt_b
);

  req_t prio;

  always_comb begin
    gnt_a = 1'b0;
    gnt_b = 1'b0;
    if (en) begin
      if (req_a && (!req_b || prio == REQ_A)) begin
        gnt_a = 1'b1;
      end else if (req_b) begin
        gnt_b = 1'b1;
      end
    end
  end

  // Priority passes to the other requester after every grant; idle cycles keep it.
  always_ff @(posedge clk) begin
    if (rst) begin
      prio <= REQ_A;
    end else if (gnt_a) begin
      prio <= REQ_B;
    end else if (gnt_b) begin
      prio <= REQ_A;
    end
  end

endmodule

// File: rtl/ram_arb_ctrl.sv
// rtl/ram_arb_ctrl.sv - scrubs a single-port RAM after reset, then shares it between two requesters
module ram_arb_ctrl
  import ram_ctrl_pkg::*;
#(
  parameter int ADDR_W         = ADDR_W_DEF,
  parameter int DATA_W         = DATA_W_DEF,
  parameter int CLEAR_ON_RESET = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              a_valid,
  output logic              a_ready,
  input  logic              a_we,
  input  logic [ADDR_W-1:0] a_addr,
  input  logic [DATA_W-1:0] a_wdata,
  output logic              a_rvalid,
  output logic [DATA_W-1:0] a_rdata,
  input  logic              b_valid,
  output logic              b_ready,
  input  logic              b_we,
  input  logic [ADDR_W-1:0] b_addr,
  input  logic [DATA_W-1:0] b_wdata,
  output logic              b_rvalid,
  output logic [DATA_W-1:0] b_rdata,
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_wdata,
  input  logic [DATA_W-1:0] ram_rdata,
  output logic              init_done
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = {ADDR_W{1'b1}};

  state_t            state;
  state_t            state_nxt;
  logic [ADDR_W-1:0] clr_addr;
  logic [ADDR_W-1:0] clr_addr_nxt;
  logic              gnt_a;
  logic              gnt_b;

  rr_arb2 u_arb (
    .clk   (clk),
    .rst   (rst),
    .en    (state == SERVE),
    .req_a (a_valid),
    .req_b (b_valid),
    .gnt_a (gnt_a),
    .gnt_b (gnt_b)
  );

  assign a_ready = gnt_a;
  assign b_ready = gnt_b;

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= (CLEAR_ON_RESET != 0) ? CLEAR : SERVE;
      clr_addr  <= '0;
      init_done <= (CLEAR_ON_RESET == 0);
    end else begin
      state    <= state_nxt;
      clr_addr <= clr_addr_nxt;
      if (state == CLEAR && clr_addr == LAST_ADDR) begin
        init_done <= 1'b1;
      end
    end
  end

  // The scrub counter parks at the last address; leaving CLEAR is what ends the sweep.
  always_comb begin
    state_nxt    = state;
    clr_addr_nxt = clr_addr;
    ram_we       = 1'b0;
    ram_addr     = '0;
    ram_wdata    = '0;
    case (state)
      CLEAR: begin
        ram_we   = 1'b1;
        ram_addr = clr_addr;
        if (clr_addr == LAST_ADDR) begin
          state_nxt = SERVE;
        end else begin
          clr_addr_nxt = clr_addr + 1'b1;
        end
      end
      SERVE: begin
        if (gnt_a) begin
          ram_we    = a_we;
          ram_addr  = a_addr;
          ram_wdata = a_wdata;
        end else if (gnt_b) begin
          ram_we    = b_we;
          ram_addr  = b_addr;
          ram_wdata = b_wdata;
        end
      end
    endcase
  end

  // Read data is captured in the grant cycle and held until that requester's next read.
  always_ff @(posedge clk) begin
    if (rst) begin
      a_rvalid <= 1'b0;
      b_rvalid <= 1'b0;
      a_rdata  <= '0;
      b_rdata  <= '0;
    end else begin
      a_rvalid <= gnt_a && !a_we;
      b_rvalid <= gnt_b && !b_we;
      if (gnt_a && !a_we) begin
        a_rdata <= ram_rdata;
      end
      if (gnt_b && !b_we) begin
        b_rdata <= ram_rdata;
      end
    end
  end

endmodule

// File: tb/tb_ram_arb_ctrl.sv
// tb/tb_ram_arb_ctrl.sv - directed self-checking bench for ram_arb_ctrl with a behavioural RAM
module tb_ram_arb_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       a_valid = 1'b0, a_we = 1'b0, b_valid = 1'b0, b_we = 1'b0;
  logic [6:0] a_addr = '0, b_addr = '0;
  logic [3:0] a_wdata = '0, b_wdata = '0;
  logic       a_ready, b_ready, a_rvalid, b_rvalid;
  logic [3:0] a_rdata, b_rdata;
  logic       ram_we;
  logic [6:0] ram_addr;
  logic [3:0] ram_wdata, ram_rdata;
  logic       init_done;

  logic [3:0] mem [128];
  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  ram_arb_ctrl dut (
    .clk(clk), .rst(rst),
    .a_valid(a_valid), .a_ready(a_ready), .a_we(a_we), .a_addr(a_addr), .a_wdata(a_wdata),
    .a_rvalid(a_rvalid), .a_rdata(a_rdata),
    .b_valid(b_valid), .b_ready(b_ready), .b_we(b_we), .b_addr(b_addr), .b_wdata(b_wdata),
    .b_rvalid(b_rvalid), .b_rdata(b_rdata),
    .ram_we(ram_we), .ram_addr(ram_addr), .ram_wdata(ram_wdata), .ram_rdata(ram_rdata),
    .init_done(init_done)
  );

  always @(posedge clk) if (ram_we) mem[ram_addr] <= ram_wdata;
  assign ram_rdata = mem[ram_addr];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_cmp++;
    if (obs !== exp_v) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp_v);
    end
  endtask

  // One cycle: check responses from the previous grant, drive requests, check readies.
  task automatic step(input string tag,
                      input logic av, input logic awe, input logic [6:0] aa, input logic [3:0] ad,
                      input logic bv, input logic bwe, input logic [6:0] ba, input logic [3:0] bd,
                      input logic e_ar, input logic e_br,
                      input logic e_arv, input logic [3:0] e_ard,
                      input logic e_brv, input logic [3:0] e_brd);
    @(negedge clk);
    check({tag, ".a_rvalid"}, 32'(a_rvalid), 32'(e_arv));
    check({tag, ".b_rvalid"}, 32'(b_rvalid), 32'(e_brv));
    if (e_arv) check({tag, ".a_rdata"}, 32'(a_rdata), 32'(e_ard));
    if (e_brv) check({tag, ".b_rdata"}, 32'(b_rdata), 32'(e_brd));
    a_valid = av; a_we = awe; a_addr = aa; a_wdata = ad;
    b_valid = bv; b_we = bwe; b_addr = ba; b_wdata = bd;
    #1;
    check({tag, ".a_ready"}, 32'(a_ready), 32'(e_ar));
    check({tag, ".b_ready"}, 32'(b_ready), 32'(e_br));
  endtask

  // Expects the reset edge to have just happened; releases rst and walks the 128-cycle scrub.
  task automatic clear_sweep(input string tag);
    for (int i = 0; i < 128; i++) begin
      @(negedge clk);
      if (i == 0) begin
        rst = 1'b0;
        check({tag, ".rvalid_dropped"}, 32'({a_rvalid, b_rvalid}), 32'(0));
      end
      #1;
      check({tag, ".ram_we"}, 32'(ram_we), 32'(1));
      check({tag, ".ram_addr"}, 32'(ram_addr), 32'(i));
      check({tag, ".ram_wdata"}, 32'(ram_wdata), 32'(0));
      check({tag, ".readies"}, 32'({a_ready, b_ready}), 32'(0));
      check({tag, ".init_done"}, 32'(init_done), 32'(0));
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 128; i++) mem[i] = 4'h9;
    a_valid = 1'b1; a_addr = 7'd3;
    b_valid = 1'b1; b_addr = 7'd4;
    @(posedge clk);
    clear_sweep("clr1");

    // Requests held through the scrub are served once it ends; A has priority first.
    step("s1",  1,0,7'd3,4'h0,  1,0,7'd4,4'h0,  1,0, 0,4'h0, 0,4'h0);
    check("s1.init_done", 32'(init_done), 32'(1));
    step("s2",  1,0,7'd3,4'h0,  1,0,7'd4,4'h0,  0,1, 1,4'h0, 0,4'h0);
    step("s3",  0,0,7'd0,4'h0,  0,0,7'd0,4'h0,  0,0, 0,4'h0, 1,4'h0);
    step("s4",  0,0,7'd0,4'h0,  0,0,7'd0,4'h0,  0,0, 0,4'h0, 0,4'h0);
    check("s4.idle_we", 32'(ram_we), 32'(0));
    check("s4.idle_addr", 32'(ram_addr), 32'(0));

    // A write then read of address 5.
    step("s5",  1,1,7'd5,4'hA,  0,0,7'd0,4'h0,  1,0, 0,4'h0, 0,4'h0);
    step("s6",  1,0,7'd5,4'h0,  0,0,7'd0,4'h0,  1,0, 0,4'h0, 0,4'h0);
    step("s7",  0,0,7'd0,4'h0,  0,0,7'd0,4'h0,  0,0, 1,4'hA, 0,4'h0);

    // Preload addr 1 and 2, which also returns priority to A.
    step("s8",  1,1,7'd1,4'hC,  0,0,7'd0,4'h0,  1,0, 0,4'h0, 0,4'h0);
    check("s8.a_rdata_hold", 32'(a_rdata), 32'(4'hA));
    step("s9",  0,0,7'd0,4'h0,  1,1,7'd2,4'h6,  0,1, 0,4'h0, 0,4'h0);

    // Continuous contention alternates A, B, A, B.
    step("s10", 1,0,7'd1,4'h0,  1,0,7'd2,4'h0,  1,0, 0,4'h0, 0,4'h0);
    step("s11", 1,0,7'd1,4'h0,  1,0,7'd2,4'h0,  0,1, 1,4'hC, 0,4'h0);
    step("s12", 1,0,7'd1,4'h0,  1,0,7'd2,4'h0,  1,0, 0,4'h0, 1,4'h6);
    step("s13", 1,0,7'd1,4'h0,  1,0,7'd2,4'h0,  0,1, 1,4'hC, 0,4'h0);
    step("s14", 0,0,7'd0,4'h0,  0,0,7'd0,4'h0,  0,0, 0,4'h0, 1,4'h6);

    // Same-cycle write by A and read by B of address 10.
    step("s15", 1,1,7'd10,4'h3, 1,0,7'd10,4'h0, 1,0, 0,4'h0, 0,4'h0);
    step("s16", 0,0,7'd0,4'h0,  1,0,7'd10,4'h0, 0,1, 0,4'h0, 0,4'h0);
    step("s17", 0,0,7'd0,4'h0,  0,0,7'd0,4'h0,  0,0, 0,4'h0, 1,4'h3);

    // Address extremes do not alias.
    step("s18", 1,1,7'd127,4'hF, 0,0,7'd0,4'h0, 1,0, 0,4'h0, 0,4'h0);
    step("s19", 0,0,7'd0,4'h0,  1,1,7'd0,4'h1,  0,1, 0,4'h0, 0,4'h0);
    step("s20", 1,0,7'd127,4'h0, 1,0,7'd0,4'h0, 1,0, 0,4'h0, 0,4'h0);
    step("s21", 0,0,7'd0,4'h0,  1,0,7'd0,4'h0,  0,1, 1,4'hF, 0,4'h0);
    step("s22", 0,0,7'd0,4'h0,  0,0,7'd0,4'h0,  0,0, 0,4'h0, 1,4'h1);

    // Reset lands on a B read grant: response dropped, scrub restarts at 0.
    step("s23", 0,0,7'd0,4'h0,  1,0,7'd127,4'h0, 0,1, 0,4'h0, 0,4'h0);
    rst = 1'b1;
    clear_sweep("clr2");
    b_valid = 1'b0;

    step("s24", 1,0,7'd127,4'h0, 0,0,7'd0,4'h0, 1,0, 0,4'h0, 0,4'h0);
    check("s24.init_done", 32'(init_done), 32'(1));
    step("s25", 0,0,7'd0,4'h0,  0,0,7'd0,4'h0,  0,0, 1,4'h0, 0,4'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/ram_arb_ctrl.md
Name: ram_arb_ctrl

Overview:
- Controller for the shared single-port 128x4 RAM. The RAM has a synchronous write when enabled and a combinational read when not enabled.
- After reset it scrubs the whole RAM to zero, then shares the one port between two requesters (A, B) with round-robin arbitration.
- Returns read data on a registered response path, one cycle after the grant.
- Sits between the two client blocks and the RAM instance. The RAM keeps its own port list; this block drives it.

Parameters:
- ADDR_W, 7, address width; DEPTH = 2**ADDR_W.
- DATA_W, 4, data width.
- CLEAR_ON_RESET, 1, 1 = scrub all DEPTH words after reset; 0 = go straight to SERVE.

Ports:
- clk  in  1  clock; all logic on the rising edge.
- rst  in  1  synchronous, active-high reset.
- a_valid  in  1  requester A has a request.
- a_ready  out  1  A's request is granted this cycle.
- a_we  in  1  1 = write, 0 = read.
- a_addr  in  ADDR_W  A address.
- a_wdata  in  DATA_W  A write data.
- a_rvalid  out  1  A read response valid, one-cycle pulse.
- a_rdata  out  DATA_W  A read data.
- b_valid, b_ready, b_we, b_addr, b_wdata, b_rvalid, b_rdata: same as the A ports, for requester B.
- ram_we  out  1  RAM write enable (the RAM reads when this is 0).
- ram_addr  out  ADDR_W  RAM address.
- ram_wdata  out  DATA_W  RAM write data.
- ram_rdata  in  DATA_W  combinational RAM read data for ram_addr.
- init_done  out  1  high once the scrub is complete.

Behaviour:
- Reset (rst high at an edge) sets the following registered state:
  - state = CLEAR if CLEAR_ON_RESET, else SERVE.
  - clr_addr = 0.
  - rr_prio = A.
  - a_rvalid = b_rvalid = 0; a_rdata = b_rdata = 0.
  - init_done = 0 if CLEAR_ON_RESET, else 1.
- State CLEAR:
  - ram_we = 1, ram_addr = clr_addr, ram_wdata = 0.
  - clr_addr increments each cycle.
  - The cycle that writes DEPTH-1 moves to SERVE; init_done is 1 from the next cycle.
  - CLEAR lasts exactly DEPTH cycles (128 by default).
  - a_ready = b_ready = 0 throughout; incoming requests wait.
- State SERVE, grant logic (combinational):
  - Only one requester valid: it is granted.
  - Both valid: the requester named by rr_prio is granted.
  - Neither valid: no grant.
  - x_ready = grant_x; at most one ready is high per cycle.
  - Ready depends on valid. Requesters must not make valid depend on ready.
- rr_prio update: after any grant to X, rr_prio becomes the other requester. It is unchanged with no grant.
- RAM drive in SERVE (combinational from the granted requester):
  - ram_we = granted we; ram_addr and ram_wdata come from the granted requester.
  - With no grant: ram_we = 0, ram_addr = 0, ram_wdata = 0.
- Read response:
  - A granted read at cycle N gives x_rvalid = 1 at N+1, with x_rdata = ram_rdata sampled at N.
  - x_rdata holds its value until the next read response for that requester.
  - Writes produce no response.
  - There is no response backpressure; the client must accept it.
- Latency and throughput:
  - Write: data is in the RAM at the edge ending the grant cycle.
  - Read: 1 cycle.
  - One access per cycle.
  - Continuous contention alternates A, B, A, B…
- Read after write: a write granted at N followed by a read of the same address at N+1 or later returns the new data.
- Address boundaries: addresses 0..DEPTH-1 only; there is no wrap logic; clr_addr stops at DEPTH-1.
- Reset mid-operation:
  - Any pending response is dropped (rvalid = 0 after the reset edge).
  - CLEAR restarts at address 0.
  - All prior contents are zero after the scrub.
- rst overrides every other event in the same cycle.

Decomposition:
- Shared package ram_ctrl_pkg holds:
  - ADDR_W/DATA_W defaults;
  - a state enum {CLEAR, SERVE};
  - a requester-id enum {REQ_A, REQ_B}.
- One natural sub-module: rr_arb2 (2-way round-robin grant with its priority flop).
- Scrub counter, state register and response registers stay in the top module.

Test Plan:
- Reset 1 cycle with CLEAR_ON_RESET=1 -> ram_we=1 for exactly 128 cycles, ram_addr 0..127, ram_wdata=0; readies low throughout; init_done rises on cycle 129.
- After init: A writes addr 5 = 0xA, then A reads addr 5 -> a_rvalid pulses 1 cycle after the read grant with a_rdata=0xA; b_rvalid stays 0.
- Both valid continuously, A reading addr 1, B reading addr 2 -> grants A,B,A,B starting with A; each rvalid arrives 1 cycle after its grant with the correct data.
- A write 0x3 to addr 10 and B read addr 10 in the same cycle, rr_prio=A -> A granted first, B granted the next cycle, b_rdata=0x3.
- Write 0xF to addr 127 and 0x1 to addr 0, read both -> 0xF and 0x1 returned; there is no aliasing.
- Assert rst during a B read grant -> no b_rvalid next cycle; CLEAR restarts at addr 0; after init_done, reading addr 127 returns 0.
